// File: rtl/xorshift_pkg.sv
// Shared constants for the xorshift stream generator: shift triplets per width
// and the two-state controller encoding.
package xorshift_pkg;

  localparam int SH32_A = 13;
  localparam int SH32_B = 17;
  localparam int SH32_C = 5;

  localparam int SH64_A = 13;
  localparam int SH64_B = 7;
  localparam int SH64_C = 17;

  typedef enum logic {
    WARM = 1'b0,
    RUN  = 1'b1
  } fsm_e;

endpackage

// File: rtl/xorshift_step.sv
// One xorshift advance: x ^= x<<A; x ^= x>>B; x ^= x<<C (bits shifted out are lost).
module xorshift_step
  import xorshift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt
);

  localparam int A = (WIDTH == 64) ? SH64_A : SH32_A;
  localparam int B = (WIDTH == 64) ? SH64_B : SH32_B;
  localparam int C = (WIDTH == 64) ? SH64_C : SH32_C;

  logic [WIDTH-1:0] t1;
  logic [WIDTH-1:0] t2;

  always_comb begin
    t1  = cur ^ (cur << A);
    t2  = t1 ^ (t1 >> B);
    nxt = t2 ^ (t2 << C);
  end

endmodule

// File: rtl/xorshift_prng_stream.sv
// Xorshift PRNG with a valid/ready output stream, reseeding and optional warm-up
// advances after every (re)seed.
module xorshift_prng_stream
  import xorshift_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(32'd20240301),
  parameter int               WARMUP       = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             en,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic [31:0]      gen_count
);

  localparam logic [7:0] WARM_LAST = 8'(WARMUP - 1);

  fsm_e             fsm, fsm_nxt;
  logic [WIDTH-1:0] x, x_nxt, step_out;
  logic [WIDTH-1:0] data_nxt;
  logic             valid_nxt;
  logic [31:0]      gc_nxt;
  logic [7:0]       warm_cnt, warm_nxt;

  xorshift_step #(.WIDTH(WIDTH)) u_step (
    .cur (x),
    .nxt (step_out)
  );

  always_comb begin
    fsm_nxt   = fsm;
    x_nxt     = x;
    data_nxt  = out_data;
    valid_nxt = out_valid;
    gc_nxt    = gen_count;
    warm_nxt  = warm_cnt;
    if (seed_load) begin
      // A zero seed would lock the generator at zero forever.
      x_nxt     = (seed_in == '0) ? SEED_DEFAULT : seed_in;
      valid_nxt = 1'b0;
      gc_nxt    = '0;
      fsm_nxt   = WARM;
      warm_nxt  = '0;
    end else begin
      case (fsm)
        WARM: begin
          if (WARMUP == 0) begin
            fsm_nxt = RUN;
          end else begin
            x_nxt    = step_out;
            warm_nxt = warm_cnt + 8'd1;
            if (warm_cnt == WARM_LAST) fsm_nxt = RUN;
          end
        end
        RUN: begin
          if (out_valid && out_ready) gc_nxt = gen_count + 32'd1;
          if (en && (!out_valid || out_ready)) begin
            x_nxt     = step_out;
            data_nxt  = step_out;
            valid_nxt = 1'b1;
          end else if (out_valid && out_ready) begin
            valid_nxt = 1'b0;
          end
        end
        default: fsm_nxt = WARM;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm       <= WARM;
      x         <= SEED_DEFAULT;
      out_data  <= '0;
      out_valid <= 1'b0;
      gen_count <= '0;
      warm_cnt  <= '0;
    end else begin
      fsm       <= fsm_nxt;
      x         <= x_nxt;
      out_data  <= data_nxt;
      out_valid <= valid_nxt;
      gen_count <= gc_nxt;
      warm_cnt  <= warm_nxt;
    end
  end

  assign busy = (fsm == WARM);

endmodule

// File: tb/tb_xorshift_prng_stream.sv
// Directed bench: 32-bit stream (no warm-up), 32-bit with 3 warm-up advances,
// and a 64-bit stream against a reference xorshift model with random back-pressure.
module tb_xorshift_prng_stream;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_seed_load, a_en, a_ready, a_valid, a_busy;
  logic [31:0] a_seed_in, a_data, a_gc;
  logic        b_seed_load, b_en, b_ready, b_valid, b_busy;
  logic [31:0] b_seed_in, b_data, b_gc;
  logic        c_seed_load, c_en, c_ready, c_valid, c_busy;
  logic [63:0] c_seed_in, c_data;
  logic [31:0] c_gc;

  xorshift_prng_stream #(.WIDTH(32), .WARMUP(0)) u_a (
    .clk(clk), .rst_n(rst_n), .seed_load(a_seed_load), .seed_in(a_seed_in),
    .en(a_en), .out_ready(a_ready), .out_valid(a_valid), .out_data(a_data),
    .busy(a_busy), .gen_count(a_gc));

  xorshift_prng_stream #(.WIDTH(32), .WARMUP(3)) u_b (
    .clk(clk), .rst_n(rst_n), .seed_load(b_seed_load), .seed_in(b_seed_in),
    .en(b_en), .out_ready(b_ready), .out_valid(b_valid), .out_data(b_data),
    .busy(b_busy), .gen_count(b_gc));

  xorshift_prng_stream #(.WIDTH(64), .WARMUP(0)) u_c (
    .clk(clk), .rst_n(rst_n), .seed_load(c_seed_load), .seed_in(c_seed_in),
    .en(c_en), .out_ready(c_ready), .out_valid(c_valid), .out_data(c_data),
    .busy(c_busy), .gen_count(c_gc));

  int total, passed, failed;

  function automatic logic [31:0] step32(input logic [31:0] v);
    logic [31:0] t;
    t = v;
    t = t ^ (t << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  function automatic logic [63:0] step64(input logic [63:0] v);
    logic [63:0] t;
    t = v;
    t = t ^ (t << 13);
    t = t ^ (t >> 7);
    t = t ^ (t << 17);
    return t;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      failed = failed + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] x;
    logic [63:0] y;
    int n, cyc;
    logic r, fire, xfer;
    total = 0; passed = 0; failed = 0;
    rst_n = 1'b0;
    a_seed_load = 0; a_seed_in = '0; a_en = 0; a_ready = 0;
    b_seed_load = 0; b_seed_in = '0; b_en = 0; b_ready = 0;
    c_seed_load = 0; c_seed_in = '0; c_en = 0; c_ready = 0;
    tick; tick;
    chk("rst_valid", 64'(a_valid), 64'd0);
    chk("rst_data",  64'(a_data),  64'd0);
    chk("rst_gc",    64'(a_gc),    64'd0);
    chk("rst_busy",  64'(a_busy),  64'd1);
    chk("rst_data64", c_data, 64'd0);

    rst_n = 1'b1;
    tick;
    chk("warmup0_run", 64'(a_busy), 64'd0);

    // seed 1, free-flowing consumer
    a_seed_in = 32'd1; a_seed_load = 1; a_en = 1; a_ready = 1;
    tick;
    a_seed_load = 0;
    chk("seed_busy",  64'(a_busy),  64'd1);
    chk("seed_valid", 64'(a_valid), 64'd0);
    tick;
    chk("run_entry_valid", 64'(a_valid), 64'd0);
    tick;
    chk("first_valid", 64'(a_valid), 64'd1);
    chk("first_data",  64'(a_data),  64'd270369);
    chk("first_gc",    64'(a_gc),    64'd0);
    x = 32'd270369;
    tick;
    x = step32(x);
    chk("second_data", 64'(a_data), 64'(x));
    chk("second_gc",   64'(a_gc),   64'd1);

    // back-pressure for 5 cycles
    a_ready = 0;
    repeat (5) tick;
    chk("stall_data",  64'(a_data),  64'(x));
    chk("stall_valid", 64'(a_valid), 64'd1);
    chk("stall_gc",    64'(a_gc),    64'd1);
    a_ready = 1;
    tick;
    x = step32(x);
    chk("release_data", 64'(a_data), 64'(x));
    chk("release_gc",   64'(a_gc),   64'd2);

    // en low drains the pending value without advancing
    a_en = 0;
    tick;
    chk("drain_valid", 64'(a_valid), 64'd0);
    chk("drain_gc",    64'(a_gc),    64'd3);
    a_en = 1;
    tick;
    x = step32(x);
    chk("resume_data", 64'(a_data), 64'(x));
    chk("resume_gc",   64'(a_gc),   64'd3);

    // zero seed loaded on the same edge as a transfer
    a_seed_in = 32'd0; a_seed_load = 1;
    tick;
    a_seed_load = 0;
    chk("seedxfer_valid", 64'(a_valid), 64'd0);
    chk("seedxfer_gc",    64'(a_gc),    64'd0);
    chk("seedxfer_busy",  64'(a_busy),  64'd1);
    tick;
    x = 32'd20240301;
    for (int i = 0; i < 3; i++) begin
      tick;
      x = step32(x);
      chk("zero_seed_seq", 64'(a_data), 64'(x));
    end

    // reset mid-stream
    rst_n = 1'b0;
    tick;
    chk("midrst_valid", 64'(a_valid), 64'd0);
    chk("midrst_data",  64'(a_data),  64'd0);
    chk("midrst_gc",    64'(a_gc),    64'd0);
    chk("midrst_busy",  64'(a_busy),  64'd1);
    rst_n = 1'b1;

    // WARMUP=3
    b_seed_in = 32'd1; b_en = 1; b_ready = 1; b_seed_load = 1;
    tick;
    b_seed_load = 0;
    n = 0;
    while (b_busy && n < 20) begin
      n++;
      tick;
    end
    chk("warm_busy_cycles", 64'(n), 64'd3);
    n = 0;
    while (!b_valid && n < 20) begin
      n++;
      tick;
    end
    x = 32'd1;
    repeat (4) x = step32(x);
    chk("warm_first_data", 64'(b_data), 64'(x));

    // 64-bit, random back-pressure
    c_seed_in = 64'd1; c_en = 1; c_ready = 1; c_seed_load = 1;
    tick;
    c_seed_load = 0;
    tick; tick;
    chk("w64_first_valid", 64'(c_valid), 64'd1);
    chk("w64_first_data",  c_data, 64'h0000_0000_4082_2041);
    y = 64'h0000_0000_4082_2041;
    n = 0; cyc = 0;
    while (n < 1000 && cyc < 5000) begin
      r = 1'($urandom_range(0, 1));
      c_ready = r;
      fire = !c_valid || r;
      xfer = c_valid && r;
      tick;
      cyc++;
      if (fire) y = step64(y);
      if (xfer) n++;
      if (c_valid) chk("w64_data", c_data, y);
    end
    chk("w64_transfers", 64'(n), 64'd1000);
    chk("w64_gc", 64'(c_gc), 64'(n));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
